pipeline_hazard_controller: RTL

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard unit: load-use stall, ALU forwarding, memory-wait freeze with timeout.
// Optional perf counters behind PERF_COUNTERS_EN.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             EnM,
    output logic             EnW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          lw_stall;
    logic          mem_busy;
    logic          freeze;

    assign mem_busy = MemReqM & ~MemReadyM;
    assign freeze   = mem_busy | (state == ERR);

    assign lw_stall = (ResultSrcE == 2'b01) & (RdE != 5'd0)
                    & ((RdE == Rs1D) | (RdE == Rs2D));

    assign StallF = lw_stall | freeze;
    assign StallD = lw_stall | freeze;
    assign StallE = freeze;
    assign EnM    = ~freeze;
    assign EnW    = ~freeze;
    // Frozen ID/EX keeps PCSrcE, so a masked flush re-fires on release
    assign FlushD = PCSrcE & ~freeze;
    assign FlushE = (PCSrcE | lw_stall) & ~freeze;
    assign MemErr = (state == ERR);

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)
            ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)
            ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)
            ForwardBE = 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    state_n = WAIT;
                    cnt_n   = CW'(1);
                end
            end
            WAIT: begin
                if (MemReadyM) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else if (cnt == CW'(MEM_TIMEOUT)) begin
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ERR: begin
                state_n = ERR;
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (StallF)
                stall_q <= stall_q + CNT_W'(1);
            if (FlushE)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign StallCount = stall_q;
    assign FlushCount = flush_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
